dut_vector_sequencer: RTL and testbench
=======================================

Name: dut_vector_sequencer

Overview:
Sequences stored 50-bit stimulus vectors through the combinational dut datapath and captures each 30-bit response into a result memory. It replaces the single-shot memory-load/display bench flow with a clocked, repeatable multi-vector run. It sits between a stimulus RAM, the dut instance and a result RAM. An optional MISR compacts all responses into one signature.

Parameters:
IN_W, 50, stimulus width; equals the dut input width.
OUT_W, 30, response width; equals the dut output width.
ADDR_W, 4, vector/result address width; depth is 2**ADDR_W.
SETTLE, 1, cycles the dut input is held before capture; legal range is 1..15.

Ports:
clk  in  1  single clock
rst_n  in  1  asynchronous, active-low reset
start  in  1  one-cycle run request; sampled only in IDLE
abort  in  1  stops the run at the next edge
num_vec  in  ADDR_W+1  number of vectors to run (0..2**ADDR_W); latched on start
vec_rd  out  1  stimulus RAM read strobe
vec_addr  out  ADDR_W  stimulus RAM address
vec_data  in  IN_W  stimulus RAM data; valid exactly 1 cycle after vec_rd
dut_in  out  IN_W  registered drive to the dut input
dut_out  in  OUT_W  dut response
res_we  out  1  result RAM write strobe
res_addr  out  ADDR_W  result RAM address
res_data  out  OUT_W  result RAM write data (the captured dut_out)
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at run completion
vec_cnt  out  ADDR_W+1  number of vectors captured in the current or last run
signature  out  OUT_W  MISR value; see Optional Feature

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE. All outputs, dut_in, vec_cnt, signature, the index and the settle counter are 0.
- FSM states: IDLE, FETCH, LOAD, SETTLE, CAPTURE, DONE.
- IDLE:
  - start=1 and num_vec>0: latch num_vec, clear vec_cnt, idx and signature, go to FETCH.
  - start=1 and num_vec=0: go to DONE; no reads or writes occur.
- FETCH: vec_rd=1, vec_addr=idx; go to LOAD.
- LOAD: dut_in <= vec_data; settle counter <= SETTLE-1; go to SETTLE.
- SETTLE: if counter=0 go to CAPTURE, otherwise decrement. The state lasts exactly SETTLE cycles.
- CAPTURE:
  - res_we=1, res_addr=idx, res_data=dut_out (combinational pass-through).
  - vec_cnt++ and update the signature.
  - If idx == latched_num-1, go to DONE; otherwise idx++ and go to FETCH.
- DONE: done=1 for one cycle, then go to IDLE.
- Per-vector cost is 3+SETTLE cycles. With start sampled at edge 0, done is high in cycle N*(3+SETTLE)+1.
- dut_in holds the last applied vector after the run. It changes only in LOAD.
- start while busy is ignored. num_vec changes after start have no effect.
- abort=1 in any non-IDLE state: go to IDLE at the next edge.
  - abort has priority over the CAPTURE write: if abort=1 in CAPTURE, res_we=0 in that cycle.
  - No done pulse. vec_cnt and signature keep their partial values.
- num_vec=2**ADDR_W: the index reaches 2**ADDR_W-1 and terminates with no wrap. Values above this are clamped to 2**ADDR_W.
- res_we and vec_rd are never high in the same cycle.

Optional Feature:
Macro SEQ_MISR_EN.
- Defined: each CAPTURE performs signature <= {signature[OUT_W-2:0], signature[OUT_W-1]} ^ dut_out ^ (signature[OUT_W-1] ? 30'h20000029 : 0).
  - For OUT_W other than 30, the taps constant is the low OUT_W bits of 30'h20000029.
  - The signature is cleared on start.
- Not defined: signature is held at 0 and no MISR logic is synthesised. All other behaviour is identical.

Test Plan:
- Reset mid-run: assert rst_n=0 during SETTLE of vector 2 -> all outputs 0 immediately; state=IDLE; no res_we after release.
- Single vector, real dut, SETTLE=1: stimulus[0]=50'h0, start, num_vec=1 -> vec_rd at cycle 1; res_we at cycle 4 with res_addr=0 and res_data=30'h2554BA58; done at cycle 5; vec_cnt=1.
- Full depth: num_vec=16, SETTLE=2, stimulus[i]=i -> 16 writes at addresses 0..15, one every 5 cycles; done at cycle 81; no address wrap; busy low at cycle 82.
- num_vec=0: start -> done at cycle 1; vec_rd and res_we never asserted; vec_cnt=0.
- Abort: num_vec=8, assert abort in the CAPTURE cycle of vector 3 -> no write for that vector; vec_cnt=3; no done; a new start is accepted on the next cycle.
- SEQ_MISR_EN: run the same 4 vectors twice -> identical signature, nonzero; flipping one stimulus bit changes the signature. Without the macro, signature stays 0.

Source files
------------

// File: rtl/dut_vector_sequencer_if.sv
// Bus bundle between the vector sequencer and its environment:
// control, stimulus RAM read port, dut drive/response, result RAM write port.
interface dut_vector_sequencer_if #(
  parameter int unsigned IN_W   = 50,
  parameter int unsigned OUT_W  = 30,
  parameter int unsigned ADDR_W = 4
);
  logic              start;
  logic              abort;
  logic [ADDR_W:0]   num_vec;
  logic              vec_rd;
  logic [ADDR_W-1:0] vec_addr;
  logic [IN_W-1:0]   vec_data;
  logic [IN_W-1:0]   dut_in;
  logic [OUT_W-1:0]  dut_out;
  logic              res_we;
  logic [ADDR_W-1:0] res_addr;
  logic [OUT_W-1:0]  res_data;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   vec_cnt;
  logic [OUT_W-1:0]  signature;

  // Sequencer side
  modport master (
    input  start, abort, num_vec, vec_data, dut_out,
    output vec_rd, vec_addr, dut_in, res_we, res_addr, res_data,
           busy, done, vec_cnt, signature
  );

  // Environment side (RAMs, dut, controller)
  modport slave (
    output start, abort, num_vec, vec_data, dut_out,
    input  vec_rd, vec_addr, dut_in, res_we, res_addr, res_data,
           busy, done, vec_cnt, signature
  );
endinterface

// File: rtl/dut_vector_sequencer.sv
// Vector sequencer: fetches stimulus vectors, drives them into the dut,
// waits SETTLE cycles and writes each response into the result RAM.
// Optional response MISR enabled by defining SEQ_MISR_EN; otherwise the
// signature output is constant 0.
module dut_vector_sequencer #(
  parameter int unsigned IN_W   = 50,
  parameter int unsigned OUT_W  = 30,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned SETTLE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dut_vector_sequencer_if.master sq
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SETTLE,
    S_CAPTURE,
    S_DONE
  } state_t;

  localparam int unsigned   DEPTH       = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] MAX_NUM   = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]    SETTLE_INIT = 4'(SETTLE - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [ADDR_W:0]     num_q, num_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [IN_W-1:0]     din_q, din_d;
  logic [ADDR_W:0]     vcnt_q, vcnt_d;

`ifdef SEQ_MISR_EN
  localparam logic [OUT_W-1:0] MISR_TAPS = OUT_W'(30'h20000029);
  logic [OUT_W-1:0]    sig_q, sig_d;
  assign sq.signature = sig_q;
`else
  assign sq.signature = '0;
`endif

  assign sq.busy    = (state_q != S_IDLE);
  assign sq.vec_cnt = vcnt_q;
  assign sq.dut_in  = din_q;

  // Next-state and strobe decode
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    num_d   = num_q;
    cnt_d   = cnt_q;
    din_d   = din_q;
    vcnt_d  = vcnt_q;
`ifdef SEQ_MISR_EN
    sig_d   = sig_q;
`endif
    sq.vec_rd   = 1'b0;
    sq.vec_addr = '0;
    sq.res_we   = 1'b0;
    sq.res_addr = '0;
    sq.res_data = '0;
    sq.done     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (sq.start) begin
          vcnt_d = '0;
          idx_d  = '0;
`ifdef SEQ_MISR_EN
          sig_d  = '0;
`endif
          if (sq.num_vec == '0) begin
            state_d = S_DONE;
          end else begin
            num_d   = (sq.num_vec > MAX_NUM) ? MAX_NUM : sq.num_vec;
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        sq.vec_rd   = 1'b1;
        sq.vec_addr = idx_q;
        state_d     = S_LOAD;
      end
      S_LOAD: begin
        din_d   = sq.vec_data;
        cnt_d   = SETTLE_INIT;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == '0) state_d = S_CAPTURE;
        else             cnt_d   = cnt_q - 4'd1;
      end
      S_CAPTURE: begin
        sq.res_we   = 1'b1;
        sq.res_addr = idx_q;
        sq.res_data = sq.dut_out;
        vcnt_d      = vcnt_q + (ADDR_W + 1)'(1);
`ifdef SEQ_MISR_EN
        sig_d = {sig_q[OUT_W-2:0], sig_q[OUT_W-1]} ^ sq.dut_out ^
                (sig_q[OUT_W-1] ? MISR_TAPS : '0);
`endif
        if ({1'b0, idx_q} == num_q - (ADDR_W + 1)'(1)) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = S_FETCH;
        end
      end
      S_DONE: begin
        sq.done = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything above: drop any pending update and the
    // CAPTURE write, leaving counters and signature at their partial values.
    if (sq.abort && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      idx_d     = idx_q;
      num_d     = num_q;
      cnt_d     = cnt_q;
      din_d     = din_q;
      vcnt_d    = vcnt_q;
`ifdef SEQ_MISR_EN
      sig_d     = sig_q;
`endif
      sq.res_we = 1'b0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      num_q   <= '0;
      cnt_q   <= '0;
      din_q   <= '0;
      vcnt_q  <= '0;
`ifdef SEQ_MISR_EN
      sig_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      num_q   <= num_d;
      cnt_q   <= cnt_d;
      din_q   <= din_d;
      vcnt_q  <= vcnt_d;
`ifdef SEQ_MISR_EN
      sig_q   <= sig_d;
`endif
    end
  end

endmodule

// File: tb/tb_dut_vector_sequencer.sv
// Testbench for dut_vector_sequencer: cycle-indexed behavioural model plus
// directed literal checks. Build with or without SEQ_MISR_EN.
module tb_dut_vector_sequencer;
  localparam int unsigned IN_W   = 50;
  localparam int unsigned OUT_W  = 30;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned SETTLE = 2;
  localparam int unsigned DEPTH  = 16;
  localparam int          P      = SETTLE + 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dut_vector_sequencer_if #(.IN_W(IN_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W)) bus ();

  dut_vector_sequencer #(
    .IN_W(IN_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W), .SETTLE(SETTLE)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sq   (bus)
  );

  logic [IN_W-1:0] stim [DEPTH];

  function automatic logic [OUT_W-1:0] dut_fn(input logic [IN_W-1:0] x);
    return x[29:0] ^ {10'b0, x[49:30]} ^ 30'h2554BA58;
  endfunction

  function automatic logic [OUT_W-1:0] misr(input logic [OUT_W-1:0] s, input logic [OUT_W-1:0] d);
    return {s[28:0], s[29]} ^ d ^ (s[29] ? 30'h20000029 : 30'h0);
  endfunction

  // Combinational dut and stimulus RAM (data valid only the cycle after vec_rd)
  always_comb bus.dut_out = dut_fn(bus.dut_in);
  always @(posedge clk)
    bus.vec_data <= bus.vec_rd ? stim[bus.vec_addr] : IN_W'({$urandom, $urandom});

  // Behavioural model: a run is a numbered sequence of cycles k=1..m_len
  bit              m_act;
  int              m_k, m_len, m_n;
  logic [ADDR_W:0] m_cnt;
  logic [OUT_W-1:0] m_sig;
  logic [IN_W-1:0] m_din;

  initial begin
    int v, p, nv;
    m_act = 0; m_k = 0; m_len = 0; m_n = 0; m_cnt = '0; m_sig = '0; m_din = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_act = 0; m_k = 0; m_len = 0; m_n = 0; m_cnt = '0; m_sig = '0; m_din = '0;
      end else if (m_act) begin
        if (bus.abort) m_act = 0;
        else begin
          if (m_k < m_len) begin
            v = (m_k - 1) / P;
            p = (m_k - 1) % P;
            if (p == 1) m_din = stim[v];
            if (p == P - 1) begin
              m_cnt = m_cnt + 5'd1;
`ifdef SEQ_MISR_EN
              m_sig = misr(m_sig, dut_fn(stim[v]));
`endif
            end
          end
          if (m_k == m_len) m_act = 0;
          else m_k++;
        end
      end else if (bus.start) begin
        nv    = int'(bus.num_vec);
        m_n   = (nv > DEPTH) ? DEPTH : nv;
        m_len = (m_n == 0) ? 1 : m_n * P + 1;
        m_k   = 1;
        m_act = 1;
        m_cnt = '0;
        m_sig = '0;
      end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    int v, p;
    logic er, ew, ed;
    v = 0; p = -1;
    if (m_act && m_k < m_len) begin
      v = (m_k - 1) / P;
      p = (m_k - 1) % P;
    end
    er = m_act && (m_k < m_len) && (p == 0);
    ew = m_act && (m_k < m_len) && (p == P - 1) && !bus.abort;
    ed = m_act && (m_k == m_len);
    chk("busy",      64'(bus.busy),      64'(m_act));
    chk("done",      64'(bus.done),      64'(ed));
    chk("vec_rd",    64'(bus.vec_rd),    64'(er));
    chk("vec_addr",  64'(bus.vec_addr),  er ? 64'(v) : 64'(0));
    chk("res_we",    64'(bus.res_we),    64'(ew));
    chk("vec_cnt",   64'(bus.vec_cnt),   64'(m_cnt));
    chk("dut_in",    64'(bus.dut_in),    64'(m_din));
    chk("signature", 64'(bus.signature), 64'(m_sig));
    if (ew) begin
      chk("res_addr", 64'(bus.res_addr), 64'(v));
      chk("res_data", 64'(bus.res_data), 64'(dut_fn(stim[v])));
    end
  endtask

  // Assumes caller is 1 time unit after a rising edge; returns in cycle 1.
  task automatic pulse_start(input int n);
    bus.start   = 1'b1;
    bus.num_vec = 5'(n);
    @(posedge clk); #1;
    bus.start   = 1'b0;
    bus.num_vec = 5'($urandom);
  endtask

  task automatic run_obs(output int done_c, output int nwr, output int nrd,
                         output int nbad, output logic [OUT_W-1:0] last_data,
                         output logic [ADDR_W-1:0] last_addr);
    done_c = -1; nwr = 0; nrd = 0; nbad = 0; last_data = '0; last_addr = '0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (bus.vec_rd) nrd++;
      if (bus.res_we) begin
        if (int'(bus.res_addr) != nwr) nbad++;
        nwr++;
        last_data = bus.res_data;
        last_addr = bus.res_addr;
      end
      if (bus.done) begin
        done_c = c;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (m_act && c < 3000) begin
      @(posedge clk); #1;
      c++;
    end
    checks++;
    if (m_act) begin
      errors++;
      $display("FAIL run_timeout: still busy after %0d cycles, required idle", c);
    end
  endtask

  initial begin
    int dc, nw, nr, nb, abort_at, nv;
    logic [OUT_W-1:0] ld, sig_a, sig_exp;
    logic [ADDR_W-1:0] la;

    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.num_vec = '0;
    for (int i = 0; i < DEPTH; i++) stim[i] = '0;

    fork
      forever begin
        @(negedge clk);
        compare();
      end
    join_none

    #1;
    chk("reset_ctl", 64'({bus.busy, bus.done, bus.vec_rd, bus.res_we, bus.vec_cnt}), 64'(0));
    chk("reset_din", 64'(bus.dut_in), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Single vector of zeros
    stim[0] = '0;
    pulse_start(1);
    run_obs(dc, nw, nr, nb, ld, la);
    chk("single_done_cycle", 64'(dc), 64'(6));
    chk("single_writes",     64'(nw), 64'(1));
    chk("single_data",       64'(ld), 64'(30'h2554BA58));
    chk("single_addr",       64'(la), 64'(0));
    chk("single_vec_cnt",    64'(bus.vec_cnt), 64'(1));

    // Full depth, stim[i] = i
    for (int i = 0; i < DEPTH; i++) stim[i] = IN_W'(i);
    pulse_start(16);
    run_obs(dc, nw, nr, nb, ld, la);
    chk("full_done_cycle", 64'(dc), 64'(81));
    chk("full_writes",     64'(nw), 64'(16));
    chk("full_reads",      64'(nr), 64'(16));
    chk("full_addr_order", 64'(nb), 64'(0));
    chk("full_last_addr",  64'(la), 64'(15));
    chk("full_last_data",  64'(ld), 64'(30'h2554BA58 ^ 30'd15));
    chk("full_vec_cnt",    64'(bus.vec_cnt), 64'(16));
    @(negedge clk);
    chk("full_busy_after", 64'(bus.busy), 64'(0));
    @(posedge clk); #1;

    // Zero vectors
    pulse_start(0);
    run_obs(dc, nw, nr, nb, ld, la);
    chk("zero_done_cycle", 64'(dc), 64'(1));
    chk("zero_io", 64'({nw[7:0], nr[7:0]}), 64'(0));
    chk("zero_vec_cnt", 64'(bus.vec_cnt), 64'(0));

    // Abort in the CAPTURE cycle of vector index 3
    pulse_start(8);
    repeat (19) begin @(posedge clk); #1; end
    bus.abort = 1'b1;
    @(negedge clk);
    chk("abort_no_write", 64'(bus.res_we), 64'(0));
    @(posedge clk); #1;
    bus.abort = 1'b0;
    chk("abort_vec_cnt", 64'(bus.vec_cnt), 64'(3));
    chk("abort_idle", 64'({bus.busy, bus.done}), 64'(0));
    pulse_start(2);
    @(negedge clk);
    chk("restart_busy", 64'(bus.busy), 64'(1));
    @(posedge clk); #1;
    wait_idle();

    // Reset during SETTLE of vector index 2
    pulse_start(8);
    repeat (12) begin @(posedge clk); #1; end
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_ctl",  64'({bus.busy, bus.done, bus.vec_rd, bus.res_we, bus.vec_addr,
                             bus.res_addr, bus.vec_cnt}), 64'(0));
    chk("rst_mid_data", 64'(bus.res_data), 64'(0));
    chk("rst_mid_sig",  64'(bus.signature), 64'(0));
    chk("rst_mid_din",  64'(bus.dut_in), 64'(0));
    @(negedge clk) rst_n = 1'b1;
    nw = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.res_we) nw++;
    end
    chk("rst_no_write", 64'(nw), 64'(0));
    @(posedge clk); #1;

    // Signature: same 4 vectors twice, then one bit flipped
    for (int i = 0; i < 4; i++) stim[i] = IN_W'({$urandom, $urandom});
    sig_exp = '0;
    for (int i = 0; i < 4; i++) sig_exp = misr(sig_exp, dut_fn(stim[i]));
    pulse_start(4);
    wait_idle();
    sig_a = bus.signature;
    pulse_start(4);
    wait_idle();
`ifdef SEQ_MISR_EN
    chk("sig_run1", 64'(sig_a), 64'(sig_exp));
    chk("sig_run2", 64'(bus.signature), 64'(sig_exp));
    chk("sig_nonzero", 64'(bus.signature != '0), 64'(1));
    stim[1][7] = ~stim[1][7];
    pulse_start(4);
    wait_idle();
    chk("sig_flip_differs", 64'(bus.signature != sig_a), 64'(1));
`else
    chk("sig_off_run1", 64'(sig_a), 64'(0));
    chk("sig_off_run2", 64'(bus.signature), 64'(0));
`endif

    // Randomized runs: clamp, aborts, spurious starts, idle aborts
    repeat (30) begin
      for (int i = 0; i < DEPTH; i++) stim[i] = IN_W'({$urandom, $urandom});
      nv = int'($urandom_range(0, 20));
      abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 85)) : 0;
      pulse_start(nv);
      for (int c = 1; m_act && c < 3000; c++) begin
        bus.abort   = (c == abort_at);
        bus.start   = (m_k < m_len) && ($urandom_range(0, 7) == 0);
        bus.num_vec = 5'($urandom);
        @(posedge clk); #1;
      end
      bus.abort = 1'b0;
      bus.start = 1'b0;
      wait_idle();
      repeat ($urandom_range(0, 3)) begin
        bus.abort = 1'($urandom);
        @(posedge clk); #1;
      end
      bus.abort = 1'b0;
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
